// File: rtl/trace_chk_pkg.sv
// Shared types for the commit trace checker: golden record layout,
// record type / error kind encodings and the per-type field compare.
package trace_chk_pkg;

    localparam int TRACE_XLEN = 64;

    typedef enum logic [1:0] {
        GT_REG   = 2'd0,
        GT_STORE = 2'd1,
        GT_LOAD  = 2'd2,
        GT_CTRL  = 2'd3
    } gold_type_e;

    typedef enum logic [1:0] {
        ERR_MISMATCH  = 2'd0,
        ERR_UNMATCHED = 2'd1,
        ERR_TIMEOUT   = 2'd2
    } err_kind_e;

    // Fields are held at the widest supported XLEN, zero-extended.
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] instr;
        logic [TRACE_XLEN-1:0] value;
        logic [TRACE_XLEN-1:0] addr;
        logic [4:0]            rd;
        gold_type_e            typ;
    } trace_rec_t;

    function automatic logic rec_fields_eq(
        trace_rec_t            g,
        logic [TRACE_XLEN-1:0] value,
        logic [TRACE_XLEN-1:0] addr,
        logic [4:0]            rd
    );
        logic r;
        r = 1'b1;
        unique case (g.typ)
            GT_REG, GT_LOAD: r = (g.rd == rd) && (g.value == value);
            GT_STORE:        r = (g.addr == addr) && (g.value == value);
            GT_CTRL:         r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/trace_match_lane.sv
// Combinational search of one commit against the golden window,
// returning the oldest live, unfinished slot with equal pc and instr.
module trace_match_lane
    import trace_chk_pkg::*;
#(
    parameter int WIN = 8,
    parameter int PW  = 3
) (
    input  trace_rec_t            win_rec [WIN],
    input  logic [WIN-1:0]        win_live,
    input  logic [WIN-1:0]        win_done,
    input  logic [PW-1:0]         head,
    input  logic                  cm_valid,
    input  logic [TRACE_XLEN-1:0] cm_pc,
    input  logic [TRACE_XLEN-1:0] cm_instr,
    input  logic [TRACE_XLEN-1:0] cm_value,
    input  logic [TRACE_XLEN-1:0] cm_addr,
    input  logic [4:0]            cm_rd,
    output logic                  found,
    output logic [PW-1:0]         slot,
    output logic                  fields_eq
);

    logic [PW-1:0] idx;

    always_comb begin
        found     = 1'b0;
        slot      = '0;
        fields_eq = 1'b0;
        idx       = '0;
        for (int k = 0; k < WIN; k++) begin
            idx = PW'((int'(head) + k) % WIN);
            if (cm_valid && !found && win_live[idx] && !win_done[idx] &&
                win_rec[idx].pc == cm_pc && win_rec[idx].instr == cm_instr) begin
                found     = 1'b1;
                slot      = idx;
                fields_eq = rec_fields_eq(win_rec[idx], cm_value, cm_addr, cm_rd);
            end
        end
    end

endmodule

// File: rtl/commit_trace_checker.sv
// Golden-trace window with multi-channel out-of-order commit matching,
// in-order retire, head timeout, saturating counters and error report.
module commit_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int WIN     = 8,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gold_valid,
    output logic                   gold_ready,
    input  logic [XLEN-1:0]        gold_pc,
    input  logic [XLEN-1:0]        gold_instr,
    input  logic [XLEN-1:0]        gold_value,
    input  logic [XLEN-1:0]        gold_addr,
    input  logic [1:0]             gold_type,
    input  logic [4:0]             gold_rd,
    input  logic [NCH-1:0]         cm_valid,
    input  logic [NCH*XLEN-1:0]    cm_pc,
    input  logic [NCH*XLEN-1:0]    cm_instr,
    input  logic [NCH*XLEN-1:0]    cm_value,
    input  logic [NCH*XLEN-1:0]    cm_addr,
    input  logic [NCH*5-1:0]       cm_rd,
    output logic [CNT_W-1:0]       pass_count,
    output logic [CNT_W-1:0]       fail_count,
    output logic [CNT_W-1:0]       unmatched_count,
    output logic [CNT_W-1:0]       timeout_count,
    output logic                   err_valid,
    output logic [1:0]             err_kind,
    output logic [XLEN-1:0]        err_pc,
    output logic [$clog2(WIN):0]   occupancy
);

    localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int OW = $clog2(WIN) + 1;
    localparam int AW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = CNT_W + 1;

    trace_rec_t       rec_q [WIN];
    trace_rec_t       rec_d [WIN];
    logic [WIN-1:0]   live_q, live_d, done_q, done_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [AW-1:0]    age_q, age_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic [CNT_W-1:0] unm_q, unm_d, tmo_cnt_q, tmo_cnt_d;
    logic             err_valid_q, err_valid_d;
    err_kind_e        err_kind_q, err_kind_d;
    logic [XLEN-1:0]  err_pc_q, err_pc_d;

    trace_rec_t       gold_rec;
    logic [NCH-1:0]   l_found, l_eq;
    logic [PW-1:0]    l_slot [NCH];
    logic [NCH-1:0]   pass_v, fail_v, unm_v;
    logic [WIN-1:0]   claimed;
    logic             push, retire, tmo;

    function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
        return (p == PW'(WIN - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] c, int inc);
        logic [SW-1:0] s;
        s = {1'b0, c} + SW'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign gold_ready = (occ_q < OW'(WIN));

    always_comb begin
        gold_rec          = '0;
        gold_rec.pc       = TRACE_XLEN'(gold_pc);
        gold_rec.instr    = TRACE_XLEN'(gold_instr);
        gold_rec.value    = TRACE_XLEN'(gold_value);
        gold_rec.addr     = TRACE_XLEN'(gold_addr);
        gold_rec.rd       = gold_rd;
        gold_rec.typ      = gold_type_e'(gold_type);
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        trace_match_lane #(.WIN(WIN), .PW(PW)) u_lane (
            .win_rec   (rec_q),
            .win_live  (live_q),
            .win_done  (done_q),
            .head      (head_q),
            .cm_valid  (cm_valid[g]),
            .cm_pc     (TRACE_XLEN'(cm_pc[g*XLEN +: XLEN])),
            .cm_instr  (TRACE_XLEN'(cm_instr[g*XLEN +: XLEN])),
            .cm_value  (TRACE_XLEN'(cm_value[g*XLEN +: XLEN])),
            .cm_addr   (TRACE_XLEN'(cm_addr[g*XLEN +: XLEN])),
            .cm_rd     (cm_rd[g*5 +: 5]),
            .found     (l_found[g]),
            .slot      (l_slot[g]),
            .fields_eq (l_eq[g])
        );
    end

    always_comb begin
        rec_d   = rec_q;
        live_d  = live_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        age_d   = age_q;
        claimed = '0;
        pass_v  = '0;
        fail_v  = '0;
        unm_v   = '0;
        push    = gold_valid && gold_ready;
        retire  = live_q[head_q] && done_q[head_q];

        // Lower channels claim first; a loser on the same slot is orphaned.
        for (int ch = 0; ch < NCH; ch++) begin
            if (cm_valid[ch]) begin
                if (l_found[ch] && !claimed[l_slot[ch]]) begin
                    claimed[l_slot[ch]] = 1'b1;
                    done_d[l_slot[ch]]  = 1'b1;
                    pass_v[ch]          = l_eq[ch];
                    fail_v[ch]          = !l_eq[ch];
                end else begin
                    unm_v[ch] = 1'b1;
                end
            end
        end

        tmo = live_q[head_q] && !done_q[head_q] && !claimed[head_q] &&
              (age_q == AW'(TIMEOUT - 1));
        if (tmo) begin
            done_d[head_q] = 1'b1;
        end

        if (retire || !live_q[head_q] || tmo) begin
            age_d = '0;
        end else if (!done_q[head_q]) begin
            age_d = age_q + 1'b1;
        end

        if (retire) begin
            live_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = next_ptr(head_q);
        end
        if (push) begin
            rec_d[tail_q]  = gold_rec;
            live_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = next_ptr(tail_q);
        end
        occ_d = occ_q + OW'(push) - OW'(retire);
    end

    always_comb begin
        pass_d      = sat_add(pass_q, $countones(pass_v));
        fail_d      = sat_add(fail_q, $countones(fail_v));
        unm_d       = sat_add(unm_q, $countones(unm_v));
        tmo_cnt_d   = sat_add(tmo_cnt_q, tmo ? 1 : 0);
        err_valid_d = tmo || (|fail_v) || (|unm_v);
        err_kind_d  = err_kind_q;
        err_pc_d    = err_pc_q;
        if (tmo) begin
            err_kind_d = ERR_TIMEOUT;
            err_pc_d   = rec_q[head_q].pc[XLEN-1:0];
        end
        // Walk high to low so the lowest erring channel wins the report.
        for (int ch = NCH - 1; ch >= 0; ch--) begin
            if (fail_v[ch] || unm_v[ch]) begin
                err_kind_d = fail_v[ch] ? ERR_MISMATCH : ERR_UNMATCHED;
                err_pc_d   = cm_pc[ch*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q       <= '{default: '0};
            live_q      <= '0;
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            age_q       <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            unm_q       <= '0;
            tmo_cnt_q   <= '0;
            err_valid_q <= 1'b0;
            err_kind_q  <= ERR_MISMATCH;
            err_pc_q    <= '0;
        end else begin
            rec_q       <= rec_d;
            live_q      <= live_d;
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            age_q       <= age_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            unm_q       <= unm_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_valid_q <= err_valid_d;
            err_kind_q  <= err_kind_d;
            err_pc_q    <= err_pc_d;
        end
    end

    assign pass_count      = pass_q;
    assign fail_count      = fail_q;
    assign unmatched_count = unm_q;
    assign timeout_count   = tmo_cnt_q;
    assign err_valid       = err_valid_q;
    assign err_kind        = err_kind_q;
    assign err_pc          = err_pc_q;
    assign occupancy       = occ_q;

endmodule

// File: doc/commit_trace_checker.md
# commit_trace_checker

Synthesizable, multi-channel successor to the simulation-only golden-trace comparison in the core bench. It holds a sliding window of golden commit records, pushed in program order by a loader, and matches up to NCH out-of-order commit events per cycle against it. Events can come from the WB, MEM, branch and jump commit points of the pipeline. Each match is classified and counted as pass or fail, and orphaned or stale records are flagged. The block sits beside the core in the test harness (or FPGA debug build), fed by the same taps the bench uses.

## Interface
- NCH, 4: commit channels per cycle (1..8).
- WIN, 8: golden window depth, power of two.
- XLEN, 32: pc/instr/value/addr width.
- CNT_W, 16: counter width.
- TIMEOUT, 1024: cycles a window head may stay unmatched.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- gold_valid / gold_ready  in / out  1  golden push handshake.
- gold_pc, gold_instr, gold_value, gold_addr  in  XLEN each  golden fields.
- gold_type  in  2  0 REG, 1 STORE, 2 LOAD, 3 CTRL.
- gold_rd  in  5  destination register.
- cm_valid  in  NCH  per-channel commit strobe.
- cm_pc, cm_instr, cm_value, cm_addr  in  NCH*XLEN each  packed per channel, channel 0 in LSBs.
- cm_rd  in  NCH*5  per-channel rd.
- pass_count, fail_count, unmatched_count, timeout_count  out  CNT_W each  saturating counters.
- err_valid  out  1  one-cycle error pulse.
- err_kind  out  2  0 MISMATCH, 1 UNMATCHED, 2 TIMEOUT.
- err_pc  out  XLEN  pc of the reported error.
- occupancy  out  $clog2(WIN)+1  live window entries.

## Operation
- Window: a circular buffer with head/tail pointers; each slot has a `live` bit and a `done` bit. A push is accepted when gold_valid && gold_ready and is written at the tail. gold_ready = (occupancy < WIN), computed from registered state with no same-cycle bypass of retirement.
- Match, per valid channel: search live, not-done slots for the oldest one (nearest head) whose pc and instr are equal to the commit's.
- Compare per type:
  - REG: rd and value.
  - LOAD: rd and value.
  - STORE: addr and value.
  - CTRL: pc and instr only.
  - Equal → pass, otherwise → MISMATCH (fail). Either way the slot is set done.
- No slot found → UNMATCHED; unmatched_count increments and no slot changes.
- Same slot hit by several channels in one cycle: the lowest channel claims it. Each higher channel counts as UNMATCHED.
- Retire: when the head slot is done, clear it and advance head by one slot per cycle. Pointers wrap modulo WIN.
- Timeout: a head-age counter resets whenever head advances. When it reaches TIMEOUT with the head not done, raise TIMEOUT, increment timeout_count, force the head done, then retire it normally.
- Counters: add the per-cycle popcount of events and saturate at 2^CNT_W-1 (no wrap).
- Error report priority when several errors occur in one cycle: lowest channel first, channel errors before TIMEOUT. Every error is counted; only one is reported.

## Timing
- Reset values: all counters 0, err_valid 0, err_kind 0, err_pc 0, occupancy 0, gold_ready 1, all slots dead, head = tail = 0.
- A pushed entry becomes matchable the cycle after acceptance. A commit in the same cycle as its push is UNMATCHED.
- Commit sampled at edge N → counters and err_* updated at edge N+1, so results are visible one cycle later.
- Occupancy reflects push and retire of the previous edge. A push and a retire in the same cycle leave occupancy unchanged.
- Full window with a head retire in the same cycle: the push is refused that cycle (gold_ready was 0) and accepted the next.
- Reset asserted mid-operation discards all entries and counts at the next edge. No partial state survives.

## Structure
- Package trace_chk_pkg holds:
  - the gold_type enum (REG/STORE/LOAD/CTRL),
  - the err_kind enum,
  - a packed trace_rec_t struct {pc, instr, value, addr, rd, type}.
- Sub-module trace_match_lane, instantiated NCH times: a combinational search of one commit against the window. It outputs a found flag, a slot index and a fields-equal flag.
- The top level owns the window RAM/regs, claim arbitration, retire, timeout, counters and the error mux.

## Test plan
- Push REG {pc 0x100, instr 0x00500093, rd 1, value 5}; commit ch0 with the same fields the next cycle → pass_count 1, err_valid 0, occupancy 0 two cycles later.
- Push two entries, pc 0x100 STORE then pc 0x104 REG. Commit 0x104 on ch1 and 0x100 on ch0 in the same cycle, STORE value 0x12 against golden 0x34 → pass 1, fail 1, err_kind MISMATCH, err_pc 0x100.
- Commit pc 0x200 with the window empty → unmatched_count 1, err_kind UNMATCHED.
- Push WIN entries and hold gold_valid → gold_ready 0. Match the head → the next push is accepted one cycle after retire.
- Never match the head → after TIMEOUT cycles timeout_count 1, err_kind TIMEOUT, head advances.
- Commit the same pc/instr on ch0 and ch2 in one cycle with one golden entry → pass 1, unmatched 1, error reported on channel 2.
